strobe_timetagger: RTL and testbench

Front-end acquisition stage that timestamps rising edges on the four `strobe_in` photon-detector inputs against a free-running 36-bit counter. It emits one 47-bit record per cycle with any edge or counter wrap, with a single-cycle `data_rdy` strobe. Records feed the sample FIFO write port; bit 47 (sample-lost) is appended downstream. Control comes from the shared register bus driven by `reg_manager`.

---
 rtl/strobe_timetagger.sv | 129 ++++++++++++
 tb/tb_strobe_timetagger.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_timetagger.sv
// Timestamps rising edges on four asynchronous strobe inputs against a free-running
// 36-bit counter and emits one 47-bit record per cycle carrying edges and/or a wrap.
module strobe_timetagger #(
    parameter logic [7:0] OPERATE_ADDR = 8'h20,
    parameter logic [7:0] MASK_ADDR    = 8'h21
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  strobe_in,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  reg_data,
    input  logic        reg_wr,
    output logic        data_rdy,
    output logic [46:0] data,
    output logic        capture_operate
);

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 36;
    localparam int unsigned PAD_W = 6;

    typedef struct packed {
        logic             wrap;
        logic [PAD_W-1:0] pad;
        logic [N_CH-1:0]  hits;
        logic [CNT_W-1:0] ts;
    } rec_t;

    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [N_CH-1:0]  r_s3;
    logic [N_CH-1:0]  r_mask;
    logic             r_operate;
    logic [CNT_W-1:0] r_count;
    logic             r_data_rdy;
    rec_t             r_rec;

    logic             w_op_wr;
    logic             w_mask_wr;
    logic             w_clear;
    logic [N_CH-1:0]  w_edge;
    logic             w_wrap;
    logic             w_emit;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_unused_reg_data;

    assign w_unused_reg_data = &{1'b0, reg_data[7:4]};

    // Decode register writes and form edge/wrap events for this cycle.
    always_comb begin
        w_op_wr     = 1'b0;
        w_mask_wr   = 1'b0;
        w_clear     = 1'b0;
        w_edge      = '0;
        w_wrap      = 1'b0;
        w_emit      = 1'b0;
        w_count_nxt = r_count;

        w_op_wr   = reg_wr && (reg_addr == OPERATE_ADDR);
        w_mask_wr = reg_wr && (reg_addr == MASK_ADDR);
        w_clear   = w_op_wr && reg_data[1];
        w_edge    = r_s2 & ~r_s3 & r_mask;
        // A clear in the wrap cycle wins, so no wrap record is produced.
        w_wrap    = r_operate && !w_clear && (r_count == '1);
        w_emit    = r_operate && ((w_edge != '0) || w_wrap);

        if (w_clear) begin
            w_count_nxt = '0;
        end else if (r_operate) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Synchronizer and edge history reset high so held-high strobes never look like edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '1;
            r_s2 <= '1;
            r_s3 <= '1;
        end else begin
            r_s1 <= strobe_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_operate <= 1'b0;
            r_mask    <= '1;
        end else begin
            if (w_op_wr) begin
                r_operate <= reg_data[0];
            end
            if (w_mask_wr) begin
                r_mask <= reg_data[N_CH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Record holds its last contents between emissions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_rdy <= 1'b0;
            r_rec      <= '0;
        end else begin
            r_data_rdy <= w_emit;
            if (w_emit) begin
                r_rec.wrap <= w_wrap;
                r_rec.pad  <= '0;
                r_rec.hits <= w_edge;
                r_rec.ts   <= r_count;
            end
        end
    end

    assign data_rdy        = r_data_rdy;
    assign data            = r_rec;
    assign capture_operate = r_operate;

endmodule

// File: tb/tb_strobe_timetagger.sv
// Directed bench for strobe_timetagger: latency, masking, merging, wrap, operate gating
// and reset behaviour, with hand-computed record values.
module tb_strobe_timetagger;

    localparam logic [7:0] OP_A   = 8'h20;
    localparam logic [7:0] MASK_A = 8'h21;
    localparam logic [35:0] MAXC  = 36'hF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  strobe_in;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        reg_wr;
    logic        data_rdy;
    logic [46:0] data;
    logic        capture_operate;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_count = 0;
    int base;
    logic [35:0] preload_val;

    strobe_timetagger #(.OPERATE_ADDR(OP_A), .MASK_ADDR(MASK_A)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .strobe_in       (strobe_in),
        .reg_addr        (reg_addr),
        .reg_data        (reg_data),
        .reg_wr          (reg_wr),
        .data_rdy        (data_rdy),
        .data            (data),
        .capture_operate (capture_operate)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (data_rdy === 1'b1) rdy_count++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        reg_wr   = 1'b1;
        reg_addr = a;
        reg_data = d;
        tick(1);
        reg_wr   = 1'b0;
        reg_addr = 8'h00;
        reg_data = 8'h00;
    endtask

    function automatic logic [46:0] rec(input logic w, input logic [3:0] m, input logic [35:0] ts);
        return {w, 6'b0, m, ts};
    endfunction

    task automatic expect_rec(input string tag, input logic [46:0] exp);
        check({tag, "_rdy"}, 64'(data_rdy), 64'd1);
        check(tag, 64'(data), 64'(exp));
    endtask

    task automatic expect_hits(input string tag, input logic [3:0] m);
        check({tag, "_rdy"}, 64'(data_rdy), 64'd1);
        check(tag, 64'(data[46:36]), 64'({1'b0, 6'b0, m}));
    endtask

    // Counter must be idle (operate=0) so the forced value survives the edge.
    task automatic preload(input logic [35:0] v);
        preload_val = v;
        force dut.r_count = preload_val;
        tick(1);
        release dut.r_count;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        strobe_in = 4'hF;
        reg_addr  = 8'h00;
        reg_data  = 8'h00;
        reg_wr    = 1'b0;
        tick(2);
        check("rst_rdy", 64'(data_rdy), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_op", 64'(capture_operate), 64'd0);
        reset_n = 1'b1;

        // Held-high strobes through release: no edges
        base = rdy_count;
        wr_reg(OP_A, 8'h01);
        check("op_on", 64'(capture_operate), 64'd1);
        tick(6);
        check("held_high_none", 64'(rdy_count - base), 64'd0);
        strobe_in = 4'hE;
        tick(4);
        strobe_in = 4'hF;
        tick(3);
        expect_hits("ch0_rise", 4'b0001);
        tick(4);
        check("ch0_once", 64'(rdy_count - base), 64'd1);
        strobe_in = 4'h0;
        tick(4);
        check("fall_none", 64'(rdy_count - base), 64'd1);

        // Clear, then strobe[2] sampled 10 edges later -> ts 11, 3-edge latency
        wr_reg(OP_A, 8'h03);
        tick(9);
        strobe_in = 4'b0100;
        tick(1);
        check("lat_e1", 64'(data_rdy), 64'd0);
        tick(1);
        check("lat_e2", 64'(data_rdy), 64'd0);
        tick(1);
        expect_rec("ts11", rec(1'b0, 4'b0100, 36'd11));
        tick(1);
        check("rdy_one_cycle", 64'(data_rdy), 64'd0);
        check("data_hold", 64'(data), 64'(rec(1'b0, 4'b0100, 36'd11)));
        strobe_in = 4'h0;
        tick(4);

        strobe_in = 4'b1001;
        tick(3);
        expect_hits("merge", 4'b1001);
        strobe_in = 4'h0;
        tick(4);

        // Masking
        wr_reg(MASK_A, 8'h02);
        strobe_in = 4'hF;
        tick(3);
        expect_hits("mask_0010", 4'b0010);
        strobe_in = 4'h0;
        tick(4);
        wr_reg(MASK_A, 8'h00);
        base = rdy_count;
        strobe_in = 4'hF;
        tick(5);
        strobe_in = 4'h0;
        tick(4);
        check("mask_zero", 64'(rdy_count - base), 64'd0);
        wr_reg(MASK_A, 8'h0F);
        wr_reg(8'h30, 8'h00);
        check("other_addr_op", 64'(capture_operate), 64'd1);
        strobe_in = 4'hF;
        tick(3);
        expect_hits("other_addr_mask", 4'hF);
        strobe_in = 4'h0;
        tick(4);

        // Wrap alone, then counting resumes at 0
        wr_reg(OP_A, 8'h00);
        preload(MAXC - 36'd1);
        wr_reg(OP_A, 8'h01);
        tick(2);
        expect_rec("wrap", rec(1'b1, 4'b0000, MAXC));
        strobe_in = 4'b0010;
        tick(1);
        check("wrap_once", 64'(data_rdy), 64'd0);
        tick(2);
        expect_rec("after_wrap", rec(1'b0, 4'b0010, 36'd2));
        strobe_in = 4'h0;
        tick(4);

        // Wrap and edge in the same cycle -> single record
        wr_reg(OP_A, 8'h00);
        preload(MAXC - 36'd1);
        base = rdy_count;
        strobe_in = 4'b0100;
        wr_reg(OP_A, 8'h01);
        tick(2);
        expect_rec("wrap_edge", rec(1'b1, 4'b0100, MAXC));
        tick(3);
        check("wrap_edge_once", 64'(rdy_count - base), 64'd1);
        strobe_in = 4'h0;
        tick(4);

        // Clear on the wrap cycle suppresses the wrap record
        wr_reg(OP_A, 8'h00);
        preload(MAXC);
        base = rdy_count;
        wr_reg(OP_A, 8'h01);
        wr_reg(OP_A, 8'h03);
        strobe_in = 4'b0001;
        tick(3);
        expect_rec("clr_beats_wrap", rec(1'b0, 4'b0001, 36'd2));
        check("clr_no_wrap_rec", 64'(rdy_count - base), 64'd1);
        strobe_in = 4'h0;
        tick(4);

        // Operate off: counter frozen, no records
        wr_reg(OP_A, 8'h02);
        check("op_off", 64'(capture_operate), 64'd0);
        base = rdy_count;
        strobe_in = 4'hF;
        tick(4);
        strobe_in = 4'h0;
        tick(4);
        strobe_in = 4'hF;
        tick(4);
        strobe_in = 4'h0;
        tick(8);
        check("op_off_none", 64'(rdy_count - base), 64'd0);
        wr_reg(OP_A, 8'h01);
        strobe_in = 4'b1000;
        tick(3);
        expect_rec("frozen_ts", rec(1'b0, 4'b1000, 36'd2));
        strobe_in = 4'h0;
        tick(4);

        // Strobe already high when operate rises
        wr_reg(OP_A, 8'h00);
        strobe_in = 4'hF;
        tick(5);
        base = rdy_count;
        wr_reg(OP_A, 8'h01);
        tick(5);
        check("pre_high_none", 64'(rdy_count - base), 64'd0);
        strobe_in = 4'h0;
        tick(4);

        // Async reset while a record is out
        strobe_in = 4'hF;
        tick(3);
        check("pre_rst_rdy", 64'(data_rdy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_rdy", 64'(data_rdy), 64'd0);
        check("arst_data", 64'(data), 64'd0);
        check("arst_op", 64'(capture_operate), 64'd0);
        tick(2);
        reset_n = 1'b1;
        base = rdy_count;
        wr_reg(OP_A, 8'h01);
        strobe_in = 4'h0;
        tick(1);
        check("arst_no_partial", 64'(rdy_count - base), 64'd0);
        strobe_in = 4'hF;
        tick(3);
        expect_rec("arst_defaults", rec(1'b0, 4'hF, 36'd3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
